fdiv: RTL and testbench
=======================

Name: fdiv

Overview:
- IEEE-754 floating-point divider for the FPU datapath: result = op_a / op_b.
- Supports binary32 (mode_fp=1) and binary16 (mode_fp=0), with two rounding modes.
- Handles subnormal inputs and outputs, and raises five exception flags.
- Combinational datapath with registered outputs; a new operation can be issued every cycle.

Parameters:
- None. Format widths and constants live in the shared package.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- op_a  input  32  dividend; binary16 uses [15:0], and [31:16] is ignored
- op_b  input  32  divisor; same layout as op_a
- round_mode  input  1  1 = round-to-nearest-even, 0 = round-toward-zero (truncate)
- mode_fp  input  1  1 = binary32, 0 = binary16
- result  output  32  quotient; in binary16 mode [15:0] holds the result and [31:16] is 0
- flags  output  5  [4] invalid, [3] div-by-zero, [2] overflow, [1] underflow, [0] inexact

Behaviour:
- Clocking, reset and latency:
  - One clock (clk). Reset is synchronous, active-low (rst_n sampled at posedge clk).
  - While rst_n=0 at a posedge: result<=0, flags<=0.
  - Latency 1 cycle: inputs present before posedge N appear on result/flags after posedge N. Fully pipelined, no handshake.
  - Reset asserted mid-stream discards the in-flight result.
- Unpack:
  - Extract sign, exponent and fraction for the selected format (binary32: 8/23, bias 127; binary16: 5/10, bias 15).
  - Subnormal inputs (exp=0, frac≠0): normalize by leading-zero count, giving effective exponent 1-bias-shift and a hidden bit of 1.
- Sign: sign_a XOR sign_b, including for zero, inf and div-by-zero results.
- Special cases (priority order):
  1. Either operand NaN → canonical qNaN (0x7FC00000 / 0x7E00). Invalid is set only for a signalling NaN (quiet bit 0).
  2. 0/0 or inf/inf → qNaN, invalid.
  3. inf/finite → ±inf, no flags.
  4. finite nonzero/0 → ±inf, div-by-zero.
  5. 0/nonzero, or finite/inf → ±0, no flags.
- Normal path:
  - Quotient mantissa = (ma << (p+2)) / mb, where p = 24 or 11, plus a sticky bit from a nonzero remainder.
  - Exponent = ea - eb + bias. Normalize by one position if the quotient is below 1.
- Subnormal output: if the unbiased exponent is below emin, right-shift the mantissa by (emin - exp), ORing the shifted-out bits into sticky; exponent field becomes 0.
- Rounding:
  - round_mode=1 (RNE): increment if guard & (round | sticky | lsb).
  - round_mode=0: truncate.
  - A mantissa carry-out renormalizes; a subnormal that rounds up to the minimum normal becomes normal.
- Overflow (exponent ≥ max after rounding):
  - Sets overflow and inexact.
  - RNE → ±inf; truncate → ±max finite (0x7F7FFFFF / 0x7BFF).
- Inexact: any discarded nonzero guard/round/sticky bit.
- Underflow: set when the result is tiny (before rounding) AND inexact. An exact subnormal result raises no flags.
- Results that round to zero return ±0 with underflow and inexact set.
- Flags are sticky-free: each cycle's flags describe only that operation.

Decomposition:
- Package fdiv_pkg holds:
  - flag bit indices (FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0)
  - per-format widths and biases
  - canonical NaN constants and max-finite constants
  - an operand-class enum (ZERO, SUB, NORM, INF, QNAN, SNAN)
- One sub-module, fdiv_unpack: format-select, classify and subnormal-normalize one operand. Instantiated twice, for op_a and op_b.

Test Plan (round_mode=1, mode_fp=1 unless noted; check one cycle after applying inputs):
- 0x00800000 / 0x7F7FFFFF → result 0x00000000, flags 00011; repeat 0x3F800000 / 0x7F7FFFFF → 0x00200000, flags 00011.
- 0x00000010 / 0x3F800000 → 0x00000010, flags 00000; 0x00000020 / 0x00000010 → 0x40000000, flags 00000.
- 0x3F800000 / 0x00000000 → 0x7F800000, flags 01000; 0x00000000 / 0x00000000 → 0x7FC00000, flags 10000; 0x7F800000 / 0x7F800000 → 0x7FC00000, flags 10000.
- 0x7F7FFFFF / 0x3F000000: RNE → 0x7F800000, flags 00101; round_mode=0 → 0x7F7FFFFF, flags 00101.
- 0x3F800000 / 0x40400000 (1/3): RNE → 0x3EAAAAAB, flags 00001; round_mode=0 → 0x3EAAAAAA, flags 00001.
- mode_fp=0: 0x00003C00 / 0x00004000 → 0x00003800, flags 00000; 0x00000001 / 0x00004000 (min subnormal / 2) → 0x00000000, flags 00011. Reset: rst_n=0 for one posedge → result 0, flags 0.

Source files
------------

// File: rtl/fdiv_pkg.sv
// Shared widths, biases, special-value constants and operand classes for the divider.
// Definitions only: no latency, no flow control.
package fdiv_pkg;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // Internal exponent width covers the full quotient range of both formats
  localparam int EW = 12;
  localparam int MW = 24;

  localparam logic [EW-1:0]        BIAS32 = 12'd127;
  localparam logic [EW-1:0]        BIAS16 = 12'd15;
  localparam logic signed [EW-1:0] EMIN32 = -12'sd126;
  localparam logic signed [EW-1:0] EMIN16 = -12'sd14;
  localparam logic [EW-1:0]        EMAX32 = 12'd255;
  localparam logic [EW-1:0]        EMAX16 = 12'd31;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [15:0] QNAN16 = 16'h7E00;
  localparam logic [31:0] MAXF32 = 32'h7F7F_FFFF;
  localparam logic [15:0] MAXF16 = 16'h7BFF;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    QNAN,
    SNAN
  } op_class_e;

  // exp is unbiased two's complement; mant carries the hidden bit at [MW-1]
  typedef struct packed {
    logic            sign;
    op_class_e       cls;
    logic [EW-1:0]   exp;
    logic [MW-1:0]   mant;
  } operand_t;

  function automatic logic [4:0] lzc24(input logic [MW-1:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < MW; i++) begin
      if (v[i]) n = 5'(MW - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fdiv_unpack.sv
// Selects the format, classifies one operand and normalizes subnormals (combinational).
// No latency, no flow control.
module fdiv_unpack
  import fdiv_pkg::*;
(
  input  logic [31:0] op,
  input  logic        mode_fp,
  output operand_t    opnd
);

  logic [7:0]    exp_raw;
  logic          exp_ones;
  logic [MW-1:0] frac;
  logic [4:0]    shift;
  logic [EW-1:0] bias;

  always_comb begin
    exp_raw  = mode_fp ? op[30:23] : {3'b000, op[14:10]};
    exp_ones = mode_fp ? (&op[30:23]) : (&op[14:10]);
    // binary16 fraction is left-aligned so both formats share one datapath
    frac     = mode_fp ? {1'b0, op[22:0]} : {1'b0, op[9:0], 13'b0};
    bias     = mode_fp ? BIAS32 : BIAS16;
    shift    = lzc24(frac);

    opnd.sign = mode_fp ? op[31] : op[15];
    opnd.cls  = NORM;
    opnd.exp  = {4'b0000, exp_raw} - bias;
    opnd.mant = {1'b1, frac[MW-2:0]};

    if (exp_raw == 8'd0) begin
      if (frac == '0) begin
        opnd.cls  = ZERO;
        opnd.exp  = '0;
        opnd.mant = '0;
      end else begin
        opnd.cls  = SUB;
        opnd.exp  = 12'd1 - bias - {7'b0000000, shift};
        opnd.mant = frac << shift;
      end
    end else if (exp_ones) begin
      if (frac == '0)    opnd.cls = INF;
      else if (frac[22]) opnd.cls = QNAN;
      else               opnd.cls = SNAN;
    end
  end

endmodule

// File: rtl/fdiv.sv
// IEEE-754 binary32/binary16 divider with RNE/RZ rounding and five exception flags.
// 1-cycle latency, fully pipelined; no backpressure, a new operation is accepted every cycle.
module fdiv
  import fdiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        round_mode,
  input  logic        mode_fp,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  operand_t opnd_a;
  operand_t opnd_b;

  fdiv_unpack u_unpack_a (.op(op_a), .mode_fp(mode_fp), .opnd(opnd_a));
  fdiv_unpack u_unpack_b (.op(op_b), .mode_fp(mode_fp), .opnd(opnd_b));

  logic [MW-1:0] mb_div;
  logic [49:0]   num;
  logic [49:0]   den;
  logic [26:0]   quot;
  logic [MW-1:0] rem;

  // A zero divisor never reaches the normal path; substitute 1.0 to keep the divider defined
  assign mb_div = (opnd_b.mant == '0) ? 24'h80_0000 : opnd_b.mant;
  assign num    = {opnd_a.mant, 26'b0};
  assign den    = {26'b0, mb_div};
  assign quot   = 27'(num / den);
  assign rem    = 24'(num % den);

  logic signed [EW-1:0] ea, eb, e_q, emin, sh_full;
  logic [EW-1:0]        bias, emax, exp_base, rexp;
  logic [26:0]          n_norm, n_sh;
  logic [58:0]          ext;
  logic [4:0]           sh;
  logic [MW-1:0]        mant24;
  logic [34:0]          inc_vec, tot;
  logic                 tiny, g, s, lsb, inc, nx, ovf, sign_r;
  logic                 a_nan, b_nan, any_snan;
  logic [31:0]          inf_v, zero_v, maxf_v, qnan_v, res_d;
  logic [4:0]           flg_d;

  always_comb begin
    ea      = opnd_a.exp;
    eb      = opnd_b.exp;
    bias    = mode_fp ? BIAS32 : BIAS16;
    emin    = mode_fp ? EMIN32 : EMIN16;
    emax    = mode_fp ? EMAX32 : EMAX16;
    sign_r  = opnd_a.sign ^ opnd_b.sign;

    // Quotient lies in (0.5, 2); bring it to [1, 2) with the hidden bit at [26]
    n_norm  = quot[26] ? quot : {quot[25:0], 1'b0};
    e_q     = ea - eb - {{(EW-1){1'b0}}, ~quot[26]};

    tiny    = e_q < emin;
    sh_full = emin - e_q;
    sh      = 5'd0;
    if (tiny) sh = (sh_full > 12'sd31) ? 5'd31 : sh_full[4:0];
    ext     = {n_norm, 32'b0} >> sh;
    n_sh    = ext[58:32];

    if (mode_fp) begin
      mant24  = n_sh[26:3];
      g       = n_sh[2];
      s       = (|n_sh[1:0]) | (|ext[31:0]) | (|rem);
      lsb     = n_sh[3];
      inc_vec = 35'd1;
    end else begin
      mant24  = {n_sh[26:16], 13'b0};
      g       = n_sh[15];
      s       = (|n_sh[14:0]) | (|ext[31:0]) | (|rem);
      lsb     = n_sh[16];
      inc_vec = 35'd1 << 13;
    end

    inc = round_mode & g & (s | lsb);
    nx  = g | s;

    // Hidden bit adds the final 1 to the exponent, so mantissa carries and
    // subnormal-to-normal promotion fall out of a single add
    exp_base = tiny ? '0 : (e_q + bias - 12'd1);
    tot      = {exp_base, 23'b0} + {11'b0, mant24} + (inc ? inc_vec : 35'd0);
    rexp     = tot[34:23];
    ovf      = rexp >= emax;

    inf_v  = mode_fp ? {sign_r, 8'hFF, 23'b0}        : {16'b0, sign_r, 5'h1F, 10'b0};
    zero_v = mode_fp ? {sign_r, 31'b0}               : {16'b0, sign_r, 15'b0};
    maxf_v = mode_fp ? {sign_r, MAXF32[30:0]}        : {16'b0, sign_r, MAXF16[14:0]};
    qnan_v = mode_fp ? QNAN32                        : {16'b0, QNAN16};

    a_nan    = (opnd_a.cls == QNAN) || (opnd_a.cls == SNAN);
    b_nan    = (opnd_b.cls == QNAN) || (opnd_b.cls == SNAN);
    any_snan = (opnd_a.cls == SNAN) || (opnd_b.cls == SNAN);

    flg_d = '0;
    if (ovf) begin
      res_d         = round_mode ? inf_v : maxf_v;
      flg_d[FLG_OF] = 1'b1;
      flg_d[FLG_NX] = 1'b1;
    end else begin
      res_d = mode_fp ? {sign_r, rexp[7:0], tot[22:0]}
                      : {16'b0, sign_r, rexp[4:0], tot[22:13]};
      flg_d[FLG_UF] = tiny & nx;
      flg_d[FLG_NX] = nx;
    end

    if (a_nan || b_nan) begin
      res_d         = qnan_v;
      flg_d         = '0;
      flg_d[FLG_NV] = any_snan;
    end else if ((opnd_a.cls == ZERO && opnd_b.cls == ZERO) ||
                 (opnd_a.cls == INF  && opnd_b.cls == INF)) begin
      res_d         = qnan_v;
      flg_d         = '0;
      flg_d[FLG_NV] = 1'b1;
    end else if (opnd_a.cls == INF) begin
      res_d = inf_v;
      flg_d = '0;
    end else if (opnd_b.cls == ZERO) begin
      res_d         = inf_v;
      flg_d         = '0;
      flg_d[FLG_DZ] = 1'b1;
    end else if (opnd_a.cls == ZERO || opnd_b.cls == INF) begin
      res_d = zero_v;
      flg_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else begin
      result <= res_d;
      flags  <= flg_d;
    end
  end

endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv: directed corner vectors plus randomized operands
// compared against an exact integer-ratio reference model.
module tb_fdiv;

  logic        clk;
  logic        rst_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        round_mode;
  logic        mode_fp;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  fdiv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_a       (op_a),
    .op_b       (op_b),
    .round_mode (round_mode),
    .mode_fp    (mode_fp),
    .result     (result),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        rm;
    logic        fp;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  // Value = M * 2^E with integer M; the quotient is rounded at the ulp of its
  // (clamped) binade using exact integer quotient and remainder.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic rm, input logic fp,
                                output logic [31:0] res, output logic [4:0] flg);
    int pr, fw, bias, emaxf, emin;
    int xa, xb, ea, eb, la, lb, fl, er, k, expf;
    longint fa, fb, ma, mb, num, den, q, r, frac;
    logic s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic tiny, nx, far_away, up;
    logic [31:0] inf_v, qnan_v, zero_v, maxf_v;

    pr = fp ? 24 : 11;
    fw = pr - 1;
    bias = fp ? 127 : 15;
    emaxf = fp ? 255 : 31;
    emin = 1 - bias;
    if (fp) begin
      s = a[31] ^ b[31];
      xa = int'(a[30:23]); fa = longint'(a[22:0]);
      xb = int'(b[30:23]); fb = longint'(b[22:0]);
    end else begin
      s = a[15] ^ b[15];
      xa = int'(a[14:10]); fa = longint'(a[9:0]);
      xb = int'(b[14:10]); fb = longint'(b[9:0]);
    end
    a_nan  = (xa == emaxf) && (fa != 0);
    b_nan  = (xb == emaxf) && (fb != 0);
    a_snan = a_nan && (((fa >> (fw - 1)) & 1) == 0);
    b_snan = b_nan && (((fb >> (fw - 1)) & 1) == 0);
    a_inf  = (xa == emaxf) && (fa == 0);
    b_inf  = (xb == emaxf) && (fb == 0);
    a_zero = (xa == 0) && (fa == 0);
    b_zero = (xb == 0) && (fb == 0);

    qnan_v = fp ? 32'h7FC00000 : 32'h00007E00;
    inf_v  = fp ? {s, 31'h7F800000} : {16'h0, s, 15'h7C00};
    zero_v = fp ? {s, 31'h0} : {16'h0, s, 15'h0};
    maxf_v = fp ? {s, 31'h7F7FFFFF} : {16'h0, s, 15'h7BFF};

    res = 32'h0;
    flg = 5'b0;
    if (a_nan || b_nan) begin
      res = qnan_v;
      flg = (a_snan || b_snan) ? 5'b10000 : 5'b00000;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      res = qnan_v;
      flg = 5'b10000;
    end else if (a_inf) begin
      res = inf_v;
    end else if (b_zero) begin
      res = inf_v;
      flg = 5'b01000;
    end else if (a_zero || b_inf) begin
      res = zero_v;
    end else begin
      ma = (xa == 0) ? fa : (fa | (longint'(1) << fw));
      mb = (xb == 0) ? fb : (fb | (longint'(1) << fw));
      ea = ((xa == 0) ? 1 : xa) - bias - fw;
      eb = ((xb == 0) ? 1 : xb) - bias - fw;
      la = 0;
      lb = 0;
      for (int i = 0; i < 24; i++) begin
        if (ma[i]) la = i;
        if (mb[i]) lb = i;
      end
      fl = (la + ea) - (lb + eb);
      if ((ma << (40 - la)) < (mb << (40 - lb))) fl = fl - 1;
      tiny = fl < emin;
      er = tiny ? emin : fl;
      k = ea - eb - (er - fw);
      far_away = 1'b0;
      if (k >= 0) begin
        num = ma << k;
        den = mb;
      end else if (-k <= 38) begin
        num = ma;
        den = mb << (-k);
      end else begin
        far_away = 1'b1;
        num = ma;
        den = 1;
      end
      if (far_away) begin
        q = 0;
        r = num;
      end else begin
        q = num / den;
        r = num % den;
      end
      nx = (r != 0);
      up = 1'b0;
      if (rm && !far_away) up = (r > den - r) || ((r == den - r) && q[0]);
      q = q + longint'(up);
      if (q == (longint'(1) << pr)) begin
        q = q >> 1;
        er = er + 1;
      end
      if (q >= (longint'(1) << fw)) begin
        expf = er + bias;
        frac = q - (longint'(1) << fw);
      end else begin
        expf = 0;
        frac = q;
      end
      if (expf >= emaxf) begin
        res = rm ? inf_v : maxf_v;
        flg = 5'b00101;
      end else begin
        res = fp ? {s, 8'(expf), 23'(frac)} : {16'h0, s, 5'(expf), 10'(frac)};
        flg = {3'b000, tiny && nx, nx};
      end
    end
  endfunction

  function automatic logic [31:0] gen(input logic fp);
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 11);
    if (fp) begin
      case (sel)
        0: r[30:0]  = '0;
        1: r[30:23] = '0;
        2: r[30:0]  = 31'h7F800000;
        3: r[30:23] = 8'hFF;
        4: r[30:23] = 8'(254 - $urandom_range(0, 3));
        5: r[30:23] = 8'($urandom_range(1, 4));
        6: r[22:0]  = '0;
        7: r[30:0]  = 31'(32'd1 << $urandom_range(0, 22));
        8: r[30:23] = 8'(125 + $urandom_range(0, 4));
        default: ;
      endcase
    end else begin
      case (sel)
        0: r[14:0]  = '0;
        1: r[14:10] = '0;
        2: r[14:0]  = 15'h7C00;
        3: r[14:10] = 5'h1F;
        4: r[14:10] = 5'(30 - $urandom_range(0, 2));
        5: r[14:10] = 5'($urandom_range(1, 3));
        6: r[9:0]   = '0;
        7: r[14:0]  = 15'(32'd1 << $urandom_range(0, 9));
        8: r[14:10] = 5'(13 + $urandom_range(0, 4));
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic rm, input logic fp);
    op_a = a;
    op_b = b;
    round_mode = rm;
    mode_fp = fp;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(32'h3F800000, 32'h40400000, 1'b1, 1'b1);
    checks++;
    if (result !== 32'h0 || flags !== 5'b0) begin
      failures++;
      $display("FAIL reset result=%h flags=%b expected 00000000 00000", result, flags);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[20];
    v[0]  = '{32'h00800000, 32'h7F7FFFFF, 1'b1, 1'b1, 32'h00000000, 5'b00011};
    v[1]  = '{32'h3F800000, 32'h7F7FFFFF, 1'b1, 1'b1, 32'h00200000, 5'b00011};
    v[2]  = '{32'h00000010, 32'h3F800000, 1'b1, 1'b1, 32'h00000010, 5'b00000};
    v[3]  = '{32'h00000020, 32'h00000010, 1'b1, 1'b1, 32'h40000000, 5'b00000};
    v[4]  = '{32'h3F800000, 32'h00000000, 1'b1, 1'b1, 32'h7F800000, 5'b01000};
    v[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h7FC00000, 5'b10000};
    v[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000, 5'b10000};
    v[7]  = '{32'h7F7FFFFF, 32'h3F000000, 1'b1, 1'b1, 32'h7F800000, 5'b00101};
    v[8]  = '{32'h7F7FFFFF, 32'h3F000000, 1'b0, 1'b1, 32'h7F7FFFFF, 5'b00101};
    v[9]  = '{32'h3F800000, 32'h40400000, 1'b1, 1'b1, 32'h3EAAAAAB, 5'b00001};
    v[10] = '{32'h3F800000, 32'h40400000, 1'b0, 1'b1, 32'h3EAAAAAA, 5'b00001};
    v[11] = '{32'h00003C00, 32'h00004000, 1'b1, 1'b0, 32'h00003800, 5'b00000};
    v[12] = '{32'h00000001, 32'h00004000, 1'b1, 1'b0, 32'h00000000, 5'b00011};
    v[13] = '{32'h7F800001, 32'h3F800000, 1'b1, 1'b1, 32'h7FC00000, 5'b10000};
    v[14] = '{32'h7FC00001, 32'h00000000, 1'b1, 1'b1, 32'h7FC00000, 5'b00000};
    v[15] = '{32'hFF800000, 32'h3F800000, 1'b1, 1'b1, 32'hFF800000, 5'b00000};
    v[16] = '{32'h80000000, 32'h40A00000, 1'b1, 1'b1, 32'h80000000, 5'b00000};
    v[17] = '{32'h3F800000, 32'hFF800000, 1'b1, 1'b1, 32'h80000000, 5'b00000};
    v[18] = '{32'hABCD3C00, 32'h12344000, 1'b1, 1'b0, 32'h00003800, 5'b00000};
    v[19] = '{32'h00003C00, 32'h00008000, 1'b1, 1'b0, 32'h0000FC00, 5'b01000};
    for (int i = 0; i < 20; i++) begin
      drive(v[i].a, v[i].b, v[i].rm, v[i].fp);
      checks++;
      if (result !== v[i].res || flags !== v[i].flg) begin
        failures++;
        $display("FAIL directed[%0d] a=%h b=%h result=%h flags=%b expected %h %b",
                 i, v[i].a, v[i].b, result, flags, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_random(input logic fp, input int n);
    logic [31:0] a, b, er;
    logic [4:0]  ef;
    logic        rm;
    for (int i = 0; i < n; i++) begin
      a = gen(fp);
      b = gen(fp);
      rm = 1'($urandom_range(0, 1));
      model(a, b, rm, fp, er, ef);
      drive(a, b, rm, fp);
      checks++;
      if (result !== er || flags !== ef) begin
        failures++;
        $display("FAIL random_fp%0d a=%h b=%h rm=%0d result=%h flags=%b expected %h %b",
                 fp, a, b, rm, result, flags, er, ef);
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [31:0] a, b, er;
    logic [4:0]  ef;
    logic        rm, fp;
    for (int i = 0; i < n; i++) begin
      fp = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      a = gen(fp);
      b = gen(fp);
      model(a, b, rm, fp, er, ef);
      drive(a, b, rm, fp);
      checks++;
      if (result !== er || flags !== ef) begin
        failures++;
        $display("FAIL back_to_back a=%h b=%h rm=%0d fp=%0d result=%h flags=%b expected %h %b",
                 a, b, rm, fp, result, flags, er, ef);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(32'h7F7FFFFF, 32'h3F000000, 1'b1, 1'b1);
    checks++;
    if (result !== 32'h7F800000 || flags !== 5'b00101) begin
      failures++;
      $display("FAIL pre_reset result=%h flags=%b expected 7f800000 00101", result, flags);
    end
    rst_n = 1'b0;
    drive(32'h3F800000, 32'h40400000, 1'b1, 1'b1);
    checks++;
    if (result !== 32'h0 || flags !== 5'b0) begin
      failures++;
      $display("FAIL midstream_reset result=%h flags=%b expected 00000000 00000", result, flags);
    end
    rst_n = 1'b1;
    drive(32'h3F800000, 32'h40400000, 1'b0, 1'b1);
    checks++;
    if (result !== 32'h3EAAAAAA || flags !== 5'b00001) begin
      failures++;
      $display("FAIL post_reset result=%h flags=%b expected 3eaaaaaa 00001", result, flags);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    op_a = '0;
    op_b = '0;
    round_mode = 1'b1;
    mode_fp = 1'b1;
    test_reset();
    test_directed();
    test_random(1'b1, 400);
    test_random(1'b0, 400);
    test_back_to_back(300);
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
